// File: rtl/dc_bus_arb_if.sv
// Purpose : bundles the requester-side and bus-interface-side signals of dc_bus_arb.
// Latency : none, wires only.
// Backpressure: none; the arbiter throttles requesters through O_GNT/O_ACK.
//
// Port summary:
//   I_REQ/I_RD/I_WR [2:0]   per-requester request level and direction
//   I_CMDn/I_WORDSn/I_WDATAn requester command, word count, write data (n = 0..2)
//   I_DONE, I_RDATA         completion pulse and read data from the bus interface
//   O_GNT/O_ACK [2:0], O_ERR, O_RDATA   requester-side results
//   O_START/O_READ/O_WRITE/O_CMD/O_WORDS/O_WDATA  bus-interface command
// Modports: slave = arbiter view, master = requesters + bus-interface view.
interface dc_bus_arb_if;
    logic [2:0]  I_REQ;
    logic [2:0]  I_RD;
    logic [2:0]  I_WR;
    logic [7:0]  I_CMD0;
    logic [7:0]  I_CMD1;
    logic [7:0]  I_CMD2;
    logic [5:0]  I_WORDS0;
    logic [5:0]  I_WORDS1;
    logic [5:0]  I_WORDS2;
    logic [31:0] I_WDATA0;
    logic [31:0] I_WDATA1;
    logic [31:0] I_WDATA2;
    logic        I_DONE;
    logic [31:0] I_RDATA;

    logic [2:0]  O_GNT;
    logic [2:0]  O_ACK;
    logic        O_ERR;
    logic [31:0] O_RDATA;
    logic        O_START;
    logic        O_READ;
    logic        O_WRITE;
    logic [7:0]  O_CMD;
    logic [5:0]  O_WORDS;
    logic [31:0] O_WDATA;

    modport slave (
        input  I_REQ, I_RD, I_WR,
        input  I_CMD0, I_CMD1, I_CMD2,
        input  I_WORDS0, I_WORDS1, I_WORDS2,
        input  I_WDATA0, I_WDATA1, I_WDATA2,
        input  I_DONE, I_RDATA,
        output O_GNT, O_ACK, O_ERR, O_RDATA,
        output O_START, O_READ, O_WRITE, O_CMD, O_WORDS, O_WDATA
    );

    modport master (
        output I_REQ, I_RD, I_WR,
        output I_CMD0, I_CMD1, I_CMD2,
        output I_WORDS0, I_WORDS1, I_WORDS2,
        output I_WDATA0, I_WDATA1, I_WDATA2,
        output I_DONE, I_RDATA,
        input  O_GNT, O_ACK, O_ERR, O_RDATA,
        input  O_START, O_READ, O_WRITE, O_CMD, O_WORDS, O_WDATA
    );
endinterface

// File: rtl/dc_bus_arb.sv
// Purpose : round-robin arbiter giving three requesters turns on one D13 bus interface.
// Latency : request in IDLE to O_START = 2 cycles; O_ACK 1 cycle after I_DONE or timeout.
// Backpressure: requesters hold I_REQ until O_ACK; one transfer in flight, GAP_CYC idle cycles between.
//
// Ports:
//   I_CLK   clock (50 MHz)
//   I_RSTF  asynchronous active-low reset
//   io_bus  dc_bus_arb_if.slave: requester inputs, bus-interface handshake, all outputs
// Parameters:
//   TMO_CYC  cycles to wait for I_DONE before abandoning a transfer (must fit the 10-bit counter)
//   GAP_CYC  idle cycles inserted after every acknowledge
module dc_bus_arb #(
    parameter int TMO_CYC = 1023,
    parameter int GAP_CYC = 2
) (
    input  logic         I_CLK,
    input  logic         I_RSTF,
    dc_bus_arb_if.slave  io_bus
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_last;
    logic [2:0]  r_gnt;
    logic [2:0]  r_ack;
    logic        r_err;
    logic        r_start;
    logic        r_read;
    logic        r_write;
    logic [7:0]  r_cmd;
    logic [5:0]  r_words;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [9:0]  r_tmo;
    logic [GW-1:0] r_gap;

    logic        w_found;
    logic [1:0]  w_win;
    logic        w_rd;
    logic        w_wr;
    logic [7:0]  w_cmd;
    logic [5:0]  w_words;
    logic [31:0] w_wdata;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        int cand;
        cand    = 0;
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = (int'(r_last) + 1 + k) % 3;
            if (!w_found && io_bus.I_REQ[2'(cand)]) begin
                w_found = 1'b1;
                w_win   = 2'(cand);
            end
        end
    end

    // Winner's transfer parameters; read beats write when both are set.
    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_cmd   = io_bus.I_CMD0;
        w_words = io_bus.I_WORDS0;
        w_wdata = io_bus.I_WDATA0;
        case (w_win)
            2'd1: begin
                w_rd    = io_bus.I_RD[1];
                w_wr    = io_bus.I_WR[1] & ~io_bus.I_RD[1];
                w_cmd   = io_bus.I_CMD1;
                w_words = io_bus.I_WORDS1;
                w_wdata = io_bus.I_WDATA1;
            end
            2'd2: begin
                w_rd    = io_bus.I_RD[2];
                w_wr    = io_bus.I_WR[2] & ~io_bus.I_RD[2];
                w_cmd   = io_bus.I_CMD2;
                w_words = io_bus.I_WORDS2;
                w_wdata = io_bus.I_WDATA2;
            end
            default: begin
                w_rd    = io_bus.I_RD[0];
                w_wr    = io_bus.I_WR[0] & ~io_bus.I_RD[0];
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd2;
            r_gnt   <= 3'b000;
            r_ack   <= 3'b000;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_cmd   <= 8'h00;
            r_words <= 6'd0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_tmo   <= 10'd0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.I_REQ != 3'b000) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // A request withdrawn during the ARB cycle simply drops back to IDLE.
                    if (w_found) begin
                        r_last  <= w_win;
                        r_gnt   <= 3'b001 << w_win;
                        r_read  <= w_rd;
                        r_write <= w_wr;
                        r_cmd   <= w_cmd;
                        r_words <= w_words;
                        r_wdata <= w_wdata;
                        r_start <= 1'b1;
                        r_state <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_start <= 1'b0;
                    r_tmo   <= 10'd0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_tmo <= r_tmo + 10'd1;
                    // I_DONE is checked first so a completion in the last wait cycle is not an error.
                    if (io_bus.I_DONE) begin
                        if (r_read) begin
                            r_rdata <= io_bus.I_RDATA;
                        end
                        r_ack   <= r_gnt;
                        r_err   <= 1'b0;
                        r_state <= ST_ACK;
                    end else if (r_tmo == 10'(TMO_CYC - 1)) begin
                        r_ack   <= r_gnt;
                        r_err   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack <= 3'b000;
                    r_err <= 1'b0;
                    r_gnt <= 3'b000;
                    r_gap <= '0;
                    r_state <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    r_gap <= r_gap + 1'b1;
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.O_GNT   = r_gnt;
    assign io_bus.O_ACK   = r_ack;
    assign io_bus.O_ERR   = r_err;
    assign io_bus.O_RDATA = r_rdata;
    assign io_bus.O_START = r_start;
    assign io_bus.O_READ  = r_read;
    assign io_bus.O_WRITE = r_write;
    assign io_bus.O_CMD   = r_cmd;
    assign io_bus.O_WORDS = r_words;
    assign io_bus.O_WDATA = r_wdata;

endmodule
